// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: instruction field positions,
// register-file geometry, the two-word assembly FSM state type and the
// ID/EX bundle struct, plus small helpers for field extraction.
// Optional feature macro used by the design: WB_BYPASS_EN (see reg_file).
// -----------------------------------------------------------------------------
package decode_pkg;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 32;
   localparam int NREGS      = 8;
   localparam int REG_ADDR_W = 3;

   // Instruction word layout: {opcode[15:11], rs[10:8], rd[7:5], shmnt[4:0]}
   localparam int OPC_LSB   = 11;
   localparam int OPC_W     = 5;
   localparam int RS_LSB    = 8;
   localparam int RD_LSB    = 5;
   localparam int SHMNT_LSB = 0;
   localparam int SHMNT_W   = 5;

   // Bit inside the opcode that marks a two-word (immediate) instruction
   localparam int IMM_FLAG_BIT = 4;

   typedef enum logic {
      ST_FIRST    = 1'b0,
      ST_WAIT_IMM = 1'b1
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [OPC_W-1:0]      opcode;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rd;
      logic [SHMNT_W-1:0]    shmnt;
      logic [DATA_W-1:0]     rs_data;
      logic [DATA_W-1:0]     rd_data;
      logic                  is_imm;
      logic [DATA_W-1:0]     imm;
      logic [ADDR_W-1:0]     next_pc;
   } idex_t;

   function automatic logic is_two_word(input logic [DATA_W-1:0] instr);
      return instr[OPC_LSB + IMM_FLAG_BIT];
   endfunction

   function automatic logic [REG_ADDR_W-1:0] rs_field(input logic [DATA_W-1:0] instr);
      return instr[RS_LSB +: REG_ADDR_W];
   endfunction

   function automatic logic [REG_ADDR_W-1:0] rd_field(input logic [DATA_W-1:0] instr);
      return instr[RD_LSB +: REG_ADDR_W];
   endfunction

   // Build a valid ID/EX bundle from an instruction word and its operands.
   function automatic idex_t build_idex(input logic [DATA_W-1:0] instr,
                                        input logic [DATA_W-1:0] rs_data,
                                        input logic [DATA_W-1:0] rd_data,
                                        input logic              is_imm,
                                        input logic [DATA_W-1:0] imm,
                                        input logic [ADDR_W-1:0] next_pc);
      idex_t b;
      b.valid   = 1'b1;
      b.opcode  = instr[OPC_LSB +: OPC_W];
      b.rs      = instr[RS_LSB +: REG_ADDR_W];
      b.rd      = instr[RD_LSB +: REG_ADDR_W];
      b.shmnt   = instr[SHMNT_LSB +: SHMNT_W];
      b.rs_data = rs_data;
      b.rd_data = rd_data;
      b.is_imm  = is_imm;
      b.imm     = imm;
      b.next_pc = next_pc;
      return b;
   endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// NREGS x DATA_W register file: one synchronous write port, two asynchronous
// read ports, asynchronous active-high reset clearing every register.
// r0 is an ordinary register (no hard-wired zero).
// Optional feature macro: WB_BYPASS_EN -- when defined, a read of the address
// being written this cycle returns the write data instead of the stored value.
//
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_we, i_waddr, i_wdata write port
//   i_raddr_a / o_rdata_a read port A
//   i_raddr_b / o_rdata_b read port B
// -----------------------------------------------------------------------------
module reg_file
   import decode_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [REG_ADDR_W-1:0] i_raddr_a,
   output logic [DATA_W-1:0]     o_rdata_a,
   input  logic [REG_ADDR_W-1:0] i_raddr_b,
   output logic [DATA_W-1:0]     o_rdata_b
);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] w_rdata_a;
   logic [DATA_W-1:0] w_rdata_b;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      w_rdata_a = r_regs[i_raddr_a];
      w_rdata_b = r_regs[i_raddr_b];
`ifdef WB_BYPASS_EN
      // Forward the in-flight write so the consumer sees the new value now.
      if (i_we && (i_waddr == i_raddr_a)) w_rdata_a = i_wdata;
      if (i_we && (i_waddr == i_raddr_b)) w_rdata_b = i_wdata;
`endif
   end

   assign o_rdata_a = w_rdata_a;
   assign o_rdata_b = w_rdata_b;

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Second pipeline stage. Takes IF/ID words, splits them into opcode/rs/rd/
// shmnt, reads both source operands from the internal register file and
// registers the ID/EX bundle. A two-word instruction (opcode bit 4 set) is
// held in a hold register until its immediate word arrives, then emitted as
// one bundle. Optional feature macro: WB_BYPASS_EN (write-back forwarding
// inside reg_file).
//
// Handshake: there is no ready signal. An IF/ID word is consumed on every
// rising edge where i_ifid_valid=1, i_stall=0 and i_flush=0. o_idex_valid
// marks a new bundle; while i_stall=1 the bundle and all state are frozen
// and fetch must hold its word. i_flush beats i_stall and empties the stage.
//
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_stall, i_flush              hazard/redirect control
//   i_ifid_valid/instr/next_pc    IF/ID buffer
//   i_wb_en/addr/data             write-back port into the register file
//   o_idex_*                      registered ID/EX buffer
//   o_dbg_state                   FSM state (0 = FIRST, 1 = WAIT_IMM)
// -----------------------------------------------------------------------------
module decode_stage
   import decode_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_ifid_valid,
   input  logic [DATA_W-1:0]     i_ifid_instr,
   input  logic [ADDR_W-1:0]     i_ifid_next_pc,
   input  logic                  i_wb_en,
   input  logic [REG_ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0]     i_wb_data,
   output logic                  o_idex_valid,
   output logic [OPC_W-1:0]      o_idex_opcode,
   output logic [REG_ADDR_W-1:0] o_idex_rs,
   output logic [REG_ADDR_W-1:0] o_idex_rd,
   output logic [SHMNT_W-1:0]    o_idex_shmnt,
   output logic [DATA_W-1:0]     o_idex_rs_data,
   output logic [DATA_W-1:0]     o_idex_rd_data,
   output logic                  o_idex_is_imm,
   output logic [DATA_W-1:0]     o_idex_imm,
   output logic [ADDR_W-1:0]     o_idex_next_pc,
   output logic                  o_dbg_state
);

   state_t                r_state;
   logic [DATA_W-1:0]     r_hold_instr;
   logic [ADDR_W-1:0]     r_hold_pc;
   idex_t                 r_idex;

   logic [REG_ADDR_W-1:0] w_rs_addr;
   logic [REG_ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0]     w_rs_data;
   logic [DATA_W-1:0]     w_rd_data;

   // Operands are read at the emitting edge: in WAIT_IMM that is the held
   // first word, so write-backs landing while we wait are picked up.
   assign w_rs_addr = (r_state == ST_WAIT_IMM) ? rs_field(r_hold_instr)
                                               : rs_field(i_ifid_instr);
   assign w_rd_addr = (r_state == ST_WAIT_IMM) ? rd_field(r_hold_instr)
                                               : rd_field(i_ifid_instr);

   reg_file u_reg_file (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (i_wb_en),
      .i_waddr   (i_wb_addr),
      .i_wdata   (i_wb_data),
      .i_raddr_a (w_rs_addr),
      .o_rdata_a (w_rs_data),
      .i_raddr_b (w_rd_addr),
      .o_rdata_b (w_rd_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_FIRST;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
         r_idex       <= '0;
      end else if (i_flush) begin
         r_idex.valid <= 1'b0;
         r_state      <= ST_FIRST;
         r_hold_instr <= '0;
         r_hold_pc    <= '0;
      end else if (!i_stall) begin
         r_idex.valid <= 1'b0;
         if (i_ifid_valid) begin
            case (r_state)
               ST_FIRST: begin
                  if (is_two_word(i_ifid_instr)) begin
                     r_hold_instr <= i_ifid_instr;
                     r_hold_pc    <= i_ifid_next_pc;
                     r_state      <= ST_WAIT_IMM;
                  end else begin
                     r_idex <= build_idex(i_ifid_instr, w_rs_data, w_rd_data,
                                          1'b0, '0, i_ifid_next_pc);
                  end
               end
               ST_WAIT_IMM: begin
                  // The incoming word is data only; its opcode bits are ignored.
                  r_idex  <= build_idex(r_hold_instr, w_rs_data, w_rd_data,
                                        1'b1, i_ifid_instr, r_hold_pc);
                  r_state <= ST_FIRST;
               end
               default: r_state <= ST_FIRST;
            endcase
         end
      end
   end

   assign o_idex_valid   = r_idex.valid;
   assign o_idex_opcode  = r_idex.opcode;
   assign o_idex_rs      = r_idex.rs;
   assign o_idex_rd      = r_idex.rd;
   assign o_idex_shmnt   = r_idex.shmnt;
   assign o_idex_rs_data = r_idex.rs_data;
   assign o_idex_rd_data = r_idex.rd_data;
   assign o_idex_is_imm  = r_idex.is_imm;
   assign o_idex_imm     = r_idex.imm;
   assign o_idex_next_pc = r_idex.next_pc;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage. Stimulus pushes the hand-computed ID/EX
// bundle into exp_q; a monitor pops and compares whenever a fresh bundle
// appears. Build with or without WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   localparam int W = 97; // {instr16, rs_data16, rd_data16, is_imm1, imm16, next_pc32}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        stall, flush;
   logic        ifid_valid;
   logic [15:0] ifid_instr;
   logic [31:0] ifid_next_pc;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;

   logic        idex_valid;
   logic [4:0]  idex_opcode;
   logic [2:0]  idex_rs, idex_rd;
   logic [4:0]  idex_shmnt;
   logic [15:0] idex_rs_data, idex_rd_data;
   logic        idex_is_imm;
   logic [15:0] idex_imm;
   logic [31:0] idex_next_pc;
   logic        dbg_state;

   decode_stage dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_stall        (stall),
      .i_flush        (flush),
      .i_ifid_valid   (ifid_valid),
      .i_ifid_instr   (ifid_instr),
      .i_ifid_next_pc (ifid_next_pc),
      .i_wb_en        (wb_en),
      .i_wb_addr      (wb_addr),
      .i_wb_data      (wb_data),
      .o_idex_valid   (idex_valid),
      .o_idex_opcode  (idex_opcode),
      .o_idex_rs      (idex_rs),
      .o_idex_rd      (idex_rd),
      .o_idex_shmnt   (idex_shmnt),
      .o_idex_rs_data (idex_rs_data),
      .o_idex_rd_data (idex_rd_data),
      .o_idex_is_imm  (idex_is_imm),
      .o_idex_imm     (idex_imm),
      .o_idex_next_pc (idex_next_pc),
      .o_dbg_state    (dbg_state)
   );

   logic [W-1:0] dut_out;
   assign dut_out = {idex_opcode, idex_rs, idex_rd, idex_shmnt,
                     idex_rs_data, idex_rd_data, idex_is_imm, idex_imm, idex_next_pc};

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;

   function automatic logic [W-1:0] pack(input logic [15:0] instr,
                                         input logic [15:0] rs_d,
                                         input logic [15:0] rd_d,
                                         input logic        is_imm,
                                         input logic [15:0] imm,
                                         input logic [31:0] pc);
      return {instr, rs_d, rd_d, is_imm, imm, pc};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a bundle is new when the last edge was neither stalled, flushed nor reset.
   logic         mon_hold;
   logic [W-1:0] mon_exp;
   always @(posedge clk) begin
      mon_hold = stall || flush || rst;
      #1;
      if (!mon_hold && !rst && idex_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", dut_out, '0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("idex_bundle", dut_out, mon_exp);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic word(input logic v, input logic [15:0] instr, input logic [31:0] pc);
      ifid_valid   = v;
      ifid_instr   = instr;
      ifid_next_pc = pc;
   endtask

   task automatic wb(input logic en, input logic [2:0] a, input logic [15:0] d);
      wb_en   = en;
      wb_addr = a;
      wb_data = d;
   endtask

   task automatic idle();
      word(1'b0, 16'h0000, 32'h0);
      wb(1'b0, 3'd0, 16'h0);
      stall = 1'b0;
      flush = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] exp_s;
   logic [15:0]  byp_r2;

   initial begin
`ifdef WB_BYPASS_EN
      byp_r2 = 16'h0055;
`else
      byp_r2 = 16'h0007;
`endif
      rst = 1'b1;
      idle();
      repeat (2) step();
      rst = 1'b0;

      // Reset state
      chk("reset_outputs", dut_out, '0);
      chk("reset_valid", {96'd0, idex_valid}, '0);
      chk("reset_state", {96'd0, dbg_state}, '0);

      // Preload r2=7, r1=9
      wb(1'b1, 3'd2, 16'h0007); step();
      wb(1'b1, 3'd1, 16'h0009); step();
      idle();

      // Single word 1A25 then back-to-back 1340 (rs=3 -> 0, rd=2 -> 7)
      word(1'b1, 16'h1A25, 32'h100);
      exp_q.push_back(pack(16'h1A25, 16'h0007, 16'h0009, 1'b0, 16'h0, 32'h100));
      step();
      word(1'b1, 16'h1340, 32'h101);
      exp_q.push_back(pack(16'h1340, 16'h0000, 16'h0007, 1'b0, 16'h0, 32'h101));
      step();

      // Two-word 8100 / BEEF with a write-back to r1 while waiting
      word(1'b1, 16'h8100, 32'h102); step();
      chk("two_word_bubble", {96'd0, idex_valid}, '0);
      chk("state_wait_imm", {96'd0, dbg_state}, {96'd0, 1'b1});
      word(1'b0, 16'h0000, 32'h0);
      wb(1'b1, 3'd1, 16'h1234); step();
      wb(1'b0, 3'd0, 16'h0);
      chk("idle_keeps_wait", {96'd0, dbg_state}, {96'd0, 1'b1});
      chk("idle_bubble", {96'd0, idex_valid}, '0);
      word(1'b1, 16'hBEEF, 32'h103);
      exp_q.push_back(pack(16'h8100, 16'h1234, 16'h0000, 1'b1, 16'hBEEF, 32'h102));
      step();
      chk("state_back_first", {96'd0, dbg_state}, '0);

      // Same-cycle write-back and read of r2
      word(1'b1, 16'h1A25, 32'h104);
      wb(1'b1, 3'd2, 16'h0055);
      exp_q.push_back(pack(16'h1A25, byp_r2, 16'h1234, 1'b0, 16'h0, 32'h104));
      step();
      wb(1'b0, 3'd0, 16'h0);

      // Flush during WAIT_IMM; flush outranks the valid word presented with it
      word(1'b1, 16'h8100, 32'h105); step();
      word(1'b1, 16'h5555, 32'h1FF);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", {96'd0, idex_valid}, '0);
      chk("flush_state", {96'd0, dbg_state}, '0);
      word(1'b1, 16'h1A25, 32'h106);
      exp_q.push_back(pack(16'h1A25, 16'h0055, 16'h1234, 1'b0, 16'h0, 32'h106));
      step();

      // Stall 3 cycles with a valid output; write r3 during the stall
      word(1'b1, 16'h1340, 32'h107);
      exp_s = pack(16'h1340, 16'h0000, 16'h0055, 1'b0, 16'h0, 32'h107);
      exp_q.push_back(exp_s);
      step();
      stall = 1'b1;
      word(1'b1, 16'h8000, 32'h108);
      wb(1'b1, 3'd3, 16'h0333);
      for (int i = 0; i < 3; i++) begin
         step();
         wb(1'b0, 3'd0, 16'h0);
         chk("stall_hold_bundle", dut_out, exp_s);
         chk("stall_hold_valid", {96'd0, idex_valid}, {96'd0, 1'b1});
      end
      chk("stall_state", {96'd0, dbg_state}, '0);
      stall = 1'b0;
      word(1'b1, 16'h1340, 32'h109);
      exp_q.push_back(pack(16'h1340, 16'h0333, 16'h0055, 1'b0, 16'h0, 32'h109));
      step();

      // Async reset in the middle of WAIT_IMM
      word(1'b1, 16'h8100, 32'h10A); step();
      idle();
      #2 rst = 1'b1;
      #1;
      chk("rst_async_outputs", dut_out, '0);
      chk("rst_async_valid", {96'd0, idex_valid}, '0);
      chk("rst_async_state", {96'd0, dbg_state}, '0);
      @(negedge clk);
      rst = 1'b0;
      word(1'b1, 16'h1A25, 32'h10B);
      exp_q.push_back(pack(16'h1A25, 16'h0000, 16'h0000, 1'b0, 16'h0, 32'h10B));
      step();
      word(1'b1, 16'h1340, 32'h10C);
      exp_q.push_back(pack(16'h1340, 16'h0000, 16'h0000, 1'b0, 16'h0, 32'h10C));
      step();
      idle();
      repeat (3) step();

      chk("all_outputs_seen", {65'd0, exp_q.size()}, '0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
